// File: rtl/clock_pkg.sv
// Shared types and BCD helpers for the 12-hour clock and its alarm stage.
// Latency: none (types, constants and a pure function).
// Backpressure: not applicable.
package clock_pkg;

  typedef enum logic [1:0] {
    ST_DISARMED = 2'd0,
    ST_ARMED    = 2'd1,
    ST_RINGING  = 2'd2,
    ST_SNOOZE   = 2'd3
  } alarm_state_e;

  localparam logic [7:0] HOUR_MIN = 8'h01;
  localparam logic [7:0] HOUR_MAX = 8'h12;
  localparam logic [7:0] MIN_MAX  = 8'h59;

  // Both nibbles must be decimal digits; once they are, BCD values compare
  // correctly as plain binary, so the upper bound is a simple magnitude check.
  function automatic logic bcd_valid(input logic [7:0] value, input logic [7:0] limit);
    return (value[7:4] <= 4'd9) && (value[3:0] <= 4'd9) && (value <= limit);
  endfunction

endpackage

// File: rtl/alarm_tick_timer.sv
// Load / count-down timer advanced by the 1 Hz tick, with a terminal strobe.
// Latency: load takes effect next clk; done is combinational on the final tick.
// Backpressure: none; tick low freezes the count.
module alarm_tick_timer #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             tick,
  output logic             done
);

  logic [WIDTH-1:0] count;

  // Load has priority; otherwise count down on tick and saturate at zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (tick && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  // The tick that consumes the last remaining count is the expiry event.
  assign done = tick && (count == WIDTH'(1));

endmodule

// File: rtl/alarm_unit_12h.sv
// Alarm stage behind the 12h BCD timekeeper: stored alarm time, arm/ring/snooze FSM.
// Latency: ring rises one clk after the first matching cycle; strobes act next clk.
// Backpressure: none; all controls are single-cycle strobes, ena low freezes timers.
module alarm_unit_12h
  import clock_pkg::*;
#(
  parameter int RING_TIMEOUT_S = 60,
  parameter int SNOOZE_MIN     = 9,
  parameter int MAX_SNOOZES    = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ena,
  input  logic [7:0] hh,
  input  logic [7:0] mm,
  input  logic [7:0] ss,
  input  logic       pm,
  input  logic       set_valid,
  input  logic [7:0] set_hh,
  input  logic [7:0] set_mm,
  input  logic       set_pm,
  input  logic       arm,
  input  logic       disarm,
  input  logic       snooze,
  input  logic       stop,
  output logic [7:0] alarm_hh,
  output logic [7:0] alarm_mm,
  output logic       alarm_pm,
  output logic       armed,
  output logic       ring,
  output logic       beep,
  output logic       snoozing,
  output logic [1:0] snooze_cnt,
  output logic       set_err
);

  localparam int SNZ_LOAD = SNOOZE_MIN * 60;
  localparam int RING_W   = $clog2(RING_TIMEOUT_S + 1);
  localparam int SNZ_W    = $clog2(SNZ_LOAD + 1);

  localparam logic [RING_W-1:0] RING_INIT = RING_W'(RING_TIMEOUT_S);
  localparam logic [SNZ_W-1:0]  SNZ_INIT  = SNZ_W'(SNZ_LOAD);
  localparam logic [1:0]        MAX_CNT   = 2'(MAX_SNOOZES);

  alarm_state_e state;
  alarm_state_e next_state;

  logic set_ok;
  logic match;
  logic match_d;
  logic trigger;
  logic in_ring;
  logic in_snz;
  logic next_ring;
  logic next_snz;
  logic cnt_clr;
  logic cnt_inc;

  logic              ring_load;
  logic [RING_W-1:0] ring_load_val;
  logic              ring_tick;
  logic              ring_done;
  logic              snz_load;
  logic [SNZ_W-1:0]  snz_load_val;
  logic              snz_tick;
  logic              snz_done;

  assign set_ok = bcd_valid(set_hh, HOUR_MAX) && (set_hh >= HOUR_MIN) &&
                  bcd_valid(set_mm, MIN_MAX);

  // Edge-detect the match so a whole matching second yields one trigger,
  // whether or not ena lines up with the first matching cycle.
  assign match   = (hh == alarm_hh) && (mm == alarm_mm) && (pm == alarm_pm) && (ss == 8'h00);
  assign trigger = match && !match_d;

  assign in_ring   = (state == ST_RINGING);
  assign in_snz    = (state == ST_SNOOZE);
  assign next_ring = (next_state == ST_RINGING);
  assign next_snz  = (next_state == ST_SNOOZE);

  // Timers only advance in their own state; they reload on entry and are
  // zeroed on exit so a stale count never carries into a later event.
  assign ring_tick     = ena && in_ring;
  assign ring_load     = next_ring ^ in_ring;
  assign ring_load_val = next_ring ? RING_INIT : '0;
  assign snz_tick      = ena && in_snz;
  assign snz_load      = next_snz ^ in_snz;
  assign snz_load_val  = next_snz ? SNZ_INIT : '0;

  alarm_tick_timer #(.WIDTH(RING_W)) u_ring_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (ring_load),
    .load_val (ring_load_val),
    .tick     (ring_tick),
    .done     (ring_done)
  );

  alarm_tick_timer #(.WIDTH(SNZ_W)) u_snz_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (snz_load),
    .load_val (snz_load_val),
    .tick     (snz_tick),
    .done     (snz_done)
  );

  // Next-state decode in priority order: disarm, stop, set, snooze, trigger/timeouts, arm.
  always_comb begin
    next_state = state;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    if (disarm) begin
      next_state = ST_DISARMED;
      cnt_clr    = 1'b1;
    end else if (stop && (in_ring || in_snz)) begin
      next_state = ST_ARMED;
      cnt_clr    = 1'b1;
    end else if (set_valid) begin
      // A new alarm time silences the current event; a rejected one changes nothing.
      if (set_ok && (in_ring || in_snz)) begin
        next_state = ST_ARMED;
        cnt_clr    = 1'b1;
      end
    end else begin
      case (state)
        ST_DISARMED: if (arm) next_state = ST_ARMED;
        ST_ARMED:    if (trigger) next_state = ST_RINGING;
        ST_RINGING: begin
          if (snooze && (snooze_cnt < MAX_CNT)) begin
            next_state = ST_SNOOZE;
            cnt_inc    = 1'b1;
          end else if (ring_done) begin
            next_state = ST_ARMED;
            cnt_clr    = 1'b1;
          end
        end
        ST_SNOOZE:   if (snz_done) next_state = ST_RINGING;
        default:     next_state = ST_DISARMED;
      endcase
    end
  end

  // State register with registered status outputs, beep and snooze count.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_DISARMED;
      armed      <= 1'b0;
      ring       <= 1'b0;
      snoozing   <= 1'b0;
      beep       <= 1'b0;
      snooze_cnt <= 2'd0;
    end else begin
      state    <= next_state;
      armed    <= (next_state != ST_DISARMED);
      ring     <= next_ring;
      snoozing <= next_snz;
      if (!next_ring) begin
        beep <= 1'b0;
      end else if (!in_ring) begin
        beep <= 1'b1;
      end else if (ena) begin
        beep <= !beep;
      end
      if (cnt_clr) begin
        snooze_cnt <= 2'd0;
      end else if (cnt_inc) begin
        snooze_cnt <= snooze_cnt + 2'd1;
      end
    end
  end

  // Alarm time storage, set_err pulse and the match history for edge detect.
  always_ff @(posedge clk) begin
    if (reset) begin
      alarm_hh <= HOUR_MAX;
      alarm_mm <= 8'h00;
      alarm_pm <= 1'b0;
      set_err  <= 1'b0;
      match_d  <= 1'b0;
    end else begin
      match_d <= match;
      set_err <= set_valid && !set_ok;
      if (set_valid && set_ok) begin
        alarm_hh <= set_hh;
        alarm_mm <= set_mm;
        alarm_pm <= set_pm;
      end
    end
  end

endmodule

// File: tb/tb_alarm_unit_12h.sv
// Directed bench for alarm_unit_12h with short timeouts (5 s ring, 1 min snooze).
// Inputs change 1 ns after posedge; outputs are checked there, away from the edge.
// Every check goes through chk(), which asserts and tallies failures.
module tb_alarm_unit_12h;

  logic       clk = 1'b0;
  logic       reset, ena, pm, set_valid, set_pm, arm, disarm, snooze, stop;
  logic [7:0] hh, mm, ss, set_hh, set_mm;
  logic [7:0] alarm_hh, alarm_mm;
  logic       alarm_pm, armed, ring, beep, snoozing, set_err;
  logic [1:0] snooze_cnt;
  logic [4:0] bseq;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alarm_unit_12h #(.RING_TIMEOUT_S(5), .SNOOZE_MIN(1), .MAX_SNOOZES(3)) dut (
    .clk(clk), .reset(reset), .ena(ena), .hh(hh), .mm(mm), .ss(ss), .pm(pm),
    .set_valid(set_valid), .set_hh(set_hh), .set_mm(set_mm), .set_pm(set_pm),
    .arm(arm), .disarm(disarm), .snooze(snooze), .stop(stop),
    .alarm_hh(alarm_hh), .alarm_mm(alarm_mm), .alarm_pm(alarm_pm),
    .armed(armed), .ring(ring), .beep(beep), .snoozing(snoozing),
    .snooze_cnt(snooze_cnt), .set_err(set_err)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ena_pulse();
    ena = 1'b1;
    tick();
    ena = 1'b0;
  endtask

  task automatic program_alarm(input logic [7:0] h, input logic [7:0] m, input logic p);
    set_valid = 1'b1; set_hh = h; set_mm = m; set_pm = p;
    tick();
    set_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; ena = 1'b0; set_valid = 1'b0; set_hh = 8'h00; set_mm = 8'h00;
    set_pm = 1'b0; arm = 1'b0; disarm = 1'b0; snooze = 1'b0; stop = 1'b0;
    hh = 8'h01; mm = 8'h00; ss = 8'h05; pm = 1'b0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_armed", 16'(armed), 16'h0);
    chk("rst_ring", 16'(ring), 16'h0);
    chk("rst_beep", 16'(beep), 16'h0);
    chk("rst_snoozing", 16'(snoozing), 16'h0);
    chk("rst_snz_cnt", 16'(snooze_cnt), 16'h0);
    chk("rst_set_err", 16'(set_err), 16'h0);
    chk("rst_alarm", {alarm_hh, alarm_mm}, 16'h1200);
    chk("rst_alarm_pm", 16'(alarm_pm), 16'h0);

    // Program 06:30 AM and arm.
    program_alarm(8'h06, 8'h30, 1'b0);
    chk("set_0630", {alarm_hh, alarm_mm}, 16'h0630);
    chk("set_0630_err", 16'(set_err), 16'h0);
    arm = 1'b1; tick(); arm = 1'b0;
    chk("arm_armed", 16'(armed), 16'h1);

    // 06:29:59 then 06:30:00 AM: ring one clk after ss=00 appears.
    hh = 8'h06; mm = 8'h29; ss = 8'h59;
    ena_pulse();
    chk("pre_match_ring", 16'(ring), 16'h0);
    mm = 8'h30; ss = 8'h00;
    chk("match_same_clk", 16'(ring), 16'h0);
    tick();
    chk("trig_ring", 16'(ring), 16'h1);
    chk("trig_beep", 16'(beep), 16'h1);
    stop = 1'b1; tick(); stop = 1'b0;
    chk("stop_ring", 16'(ring), 16'h0);
    chk("stop_armed", 16'(armed), 16'h1);
    tick();
    chk("no_retrigger", 16'(ring), 16'h0);

    // Same wall time in PM must not ring.
    pm = 1'b1; tick(); tick();
    chk("pm_no_ring", 16'(ring), 16'h0);

    // Back to AM: fresh trigger, then three full snoozes.
    pm = 1'b0; tick();
    chk("retrig_ring", 16'(ring), 16'h1);
    for (int n = 1; n <= 3; n++) begin
      snooze = 1'b1; tick(); snooze = 1'b0;
      chk("snz_snoozing", 16'(snoozing), 16'h1);
      chk("snz_cnt", 16'(snooze_cnt), 16'(n));
      chk("snz_ring", 16'(ring), 16'h0);
      repeat (59) ena_pulse();
      chk("snz_59_ring", 16'(ring), 16'h0);
      ena_pulse();
      chk("snz_60_ring", 16'(ring), 16'h1);
      chk("snz_60_beep", 16'(beep), 16'h1);
    end
    snooze = 1'b1; tick(); snooze = 1'b0;
    chk("snz4_ring", 16'(ring), 16'h1);
    chk("snz4_snoozing", 16'(snoozing), 16'h0);
    chk("snz4_cnt", 16'(snooze_cnt), 16'h3);

    // ena low freezes beep and timer; then 5 ena time out with beep 0,1,0,1,0.
    repeat (3) tick();
    chk("hold_beep", 16'(beep), 16'h1);
    chk("hold_ring", 16'(ring), 16'h1);
    bseq = 5'b01010;
    for (int i = 0; i < 5; i++) begin
      ena_pulse();
      chk("beep_seq", 16'(beep), 16'(bseq[i]));
      chk("timeout_ring", 16'(ring), (i < 4) ? 16'h1 : 16'h0);
    end
    chk("timeout_armed", 16'(armed), 16'h1);
    chk("timeout_cnt", 16'(snooze_cnt), 16'h0);

    // Invalid settings are rejected with a one-cycle set_err.
    program_alarm(8'h13, 8'h00, 1'b0);
    chk("err_h13", 16'(set_err), 16'h1);
    tick();
    chk("err_pulse_end", 16'(set_err), 16'h0);
    program_alarm(8'h06, 8'h5A, 1'b0);
    chk("err_m5a", 16'(set_err), 16'h1);
    program_alarm(8'h00, 8'h30, 1'b1);
    chk("err_h00", 16'(set_err), 16'h1);
    chk("err_keep_alarm", {alarm_hh, alarm_mm}, 16'h0630);
    chk("err_keep_pm", 16'(alarm_pm), 16'h0);
    program_alarm(8'h12, 8'h00, 1'b0);
    chk("set_1200_err", 16'(set_err), 16'h0);
    chk("set_1200", {alarm_hh, alarm_mm}, 16'h1200);
    tick();

    // disarm + snooze together while RINGING with a snooze used.
    hh = 8'h12; mm = 8'h00; ss = 8'h00; pm = 1'b0;
    tick();
    chk("ring_1200", 16'(ring), 16'h1);
    snooze = 1'b1; tick(); snooze = 1'b0;
    repeat (60) ena_pulse();
    chk("ring_again", 16'(ring), 16'h1);
    chk("ring_again_cnt", 16'(snooze_cnt), 16'h1);
    disarm = 1'b1; snooze = 1'b1; tick(); disarm = 1'b0; snooze = 1'b0;
    chk("dis_armed", 16'(armed), 16'h0);
    chk("dis_ring", 16'(ring), 16'h0);
    chk("dis_snoozing", 16'(snoozing), 16'h0);
    chk("dis_cnt", 16'(snooze_cnt), 16'h0);
    chk("dis_beep", 16'(beep), 16'h0);
    chk("dis_keep_alarm", {alarm_hh, alarm_mm}, 16'h1200);

    // stop + set_valid together: ARMED with the new time.
    arm = 1'b1; tick(); arm = 1'b0;
    ss = 8'h01; tick();
    ss = 8'h00; tick();
    chk("ring_pre_stopset", 16'(ring), 16'h1);
    stop = 1'b1; program_alarm(8'h07, 8'h15, 1'b1); stop = 1'b0;
    chk("stopset_armed", 16'(armed), 16'h1);
    chk("stopset_ring", 16'(ring), 16'h0);
    chk("stopset_alarm", {alarm_hh, alarm_mm}, 16'h0715);
    chk("stopset_pm", 16'(alarm_pm), 16'h1);

    // reset in the middle of a snooze.
    tick();
    hh = 8'h07; mm = 8'h15; ss = 8'h00; pm = 1'b1;
    tick();
    chk("ring_0715pm", 16'(ring), 16'h1);
    snooze = 1'b1; tick(); snooze = 1'b0;
    chk("pre_rst_snoozing", 16'(snoozing), 16'h1);
    repeat (10) ena_pulse();
    reset = 1'b1; tick(); reset = 1'b0;
    chk("midrst_armed", 16'(armed), 16'h0);
    chk("midrst_snoozing", 16'(snoozing), 16'h0);
    chk("midrst_cnt", 16'(snooze_cnt), 16'h0);
    chk("midrst_beep", 16'(beep), 16'h0);
    chk("midrst_alarm", {alarm_hh, alarm_mm}, 16'h1200);
    chk("midrst_pm", 16'(alarm_pm), 16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
